// File: rtl/ti_share_stage_reg.sv
// Register stage after the round-2 TI share bank: refreshes each share with fresh
// randomness on capture and buffers entries in a small FIFO with valid/ready on both sides.
module ti_share_stage_reg #(
    parameter int NS    = 3,
    parameter int SW    = 4,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NS*SW-1:0]     in_shares,
    input  logic                 rnd_valid,
    input  logic [(NS-1)*SW-1:0] rnd,
    output logic                 rnd_ack,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NS*SW-1:0]     out_shares,
    output logic [CW-1:0]        starve_cnt
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    // Handshake semantics: a transfer happens on a rising edge where valid and ready
    // are both high; ready never looks at valid, and the upstream holds its data stable
    // while ready is low.

    logic [NS*SW-1:0] mem_q [DEPTH];
    logic [NS*SW-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [NS*SW-1:0] out_q, out_d;
    logic [CW-1:0]    starve_q, starve_d;
    logic [NS*SW-1:0] refreshed;
    logic             full, push, pop;

    // Each output share sees only its own input share and the randomness words,
    // so no share-crossing logic exists before this register.
    for (genvar g = 0; g < NS; g++) begin : g_refresh
        logic [SW-1:0] r_own, r_prev;
        if (g < NS - 1) begin : g_own
            assign r_own = rnd[SW*g +: SW];
        end else begin : g_no_own
            assign r_own = '0;
        end
        if (g > 0) begin : g_prev
            assign r_prev = rnd[SW*(g-1) +: SW];
        end else begin : g_no_prev
            assign r_prev = '0;
        end
        assign refreshed[SW*g +: SW] = in_shares[SW*g +: SW] ^ r_own ^ r_prev;
    end

    assign full      = (count_q == CNTW'(DEPTH));
    assign in_ready  = rst_n & ~clr & ~full & rnd_valid;
    assign push      = in_valid & in_ready;
    assign rnd_ack   = push;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready & ~clr;
    assign out_shares = out_q;
    assign starve_cnt = starve_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        starve_d = starve_q;
        if (clr) begin
            mem_d    = '{default: '0};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            out_d    = '0;
            starve_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = refreshed;
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNTW'(push) - CNTW'(pop);
            // The output register preloads the next head; when empty it keeps the last value.
            if (count_d != '0) begin
                out_d = mem_d[rd_ptr_d];
            end
            if (in_valid && !full && !rnd_valid && (starve_q != '1)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            starve_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_ti_share_stage_reg.sv
// Directed and random checks of the share refresh stage (NS=3, SW=4, DEPTH=2, CW=3).
module tb_ti_share_stage_reg;

    localparam int NS    = 3;
    localparam int SW    = 4;
    localparam int DEPTH = 2;
    localparam int CW    = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clr;
    logic                 in_valid;
    logic                 in_ready;
    logic [NS*SW-1:0]     in_shares;
    logic                 rnd_valid;
    logic [(NS-1)*SW-1:0] rnd;
    logic                 rnd_ack;
    logic                 out_valid;
    logic                 out_ready;
    logic [NS*SW-1:0]     out_shares;
    logic [CW-1:0]        starve_cnt;

    int n_total = 0;
    int n_pass  = 0;
    logic [NS*SW-1:0] exp_q[$];

    ti_share_stage_reg #(.NS(NS), .SW(SW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_shares(in_shares),
        .rnd_valid(rnd_valid), .rnd(rnd), .rnd_ack(rnd_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_shares(out_shares),
        .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [NS*SW-1:0] model_refresh(input logic [NS*SW-1:0] s,
                                                       input logic [(NS-1)*SW-1:0] r);
        logic [3:0] s0, s1, s2, r0, r1;
        s0 = s[3:0]; s1 = s[7:4]; s2 = s[11:8];
        r0 = r[3:0]; r1 = r[7:4];
        return {s2 ^ r1, s1 ^ r0 ^ r1, s0 ^ r0};
    endfunction

    function automatic logic [3:0] xor_shares(input logic [NS*SW-1:0] s);
        return s[3:0] ^ s[7:4] ^ s[11:8];
    endfunction

    initial begin
        logic push_m, pop_m;
        logic [NS*SW-1:0] front;

        // Reset held, with an eager upstream
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_shares = 12'h935;
        rnd_valid = 1'b1; rnd = 8'h6A; out_ready = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_rnd_ack", rnd_ack, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_shares", out_shares, 0);
        chk("reset_starve", starve_cnt, 0);
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        tick();

        // Refresh of a single push into an empty FIFO
        in_valid = 1'b1; in_shares = 12'h935; rnd = 8'h6A;
        #1;
        chk("refresh_in_ready", in_ready, 1);
        chk("refresh_rnd_ack", rnd_ack, 1);
        chk("refresh_out_valid_pre", out_valid, 0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("refresh_out_valid", out_valid, 1);
        chk("refresh_out_shares", out_shares, 12'hFFF);
        chk("refresh_rnd_ack_once", rnd_ack, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("empty_out_valid", out_valid, 0);
        chk("empty_holds_last", out_shares, 12'hFFF);

        // Fill with backpressure, then pop while full
        in_valid = 1'b1; in_shares = 12'h123; rnd = 8'h00;
        #1;
        chk("fill1_in_ready", in_ready, 1);
        tick();
        in_shares = 12'h456; rnd = 8'h31;
        #1;
        chk("fill2_in_ready", in_ready, 1);
        chk("fill2_head", out_shares, 12'h123);
        tick();
        in_shares = 12'h789; rnd = 8'h00;
        #1;
        chk("full_in_ready", in_ready, 0);
        chk("full_rnd_ack", rnd_ack, 0);
        tick();
        chk("full_stays_full", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", in_ready, 0);
        chk("full_pop_head", out_shares, 12'h123);
        tick();
        #1;
        chk("after_pop_head", out_shares, 12'h777);
        chk("after_pop_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("third_head", out_shares, 12'h789);
        chk("third_valid", out_valid, 1);
        tick();
        out_ready = 1'b0;
        #1;
        chk("drained_valid", out_valid, 0);

        // Starvation counting and saturation
        in_valid = 1'b1; rnd_valid = 1'b0; in_shares = 12'hABC;
        #1;
        chk("starve_in_ready", in_ready, 0);
        chk("starve_rnd_ack", rnd_ack, 0);
        repeat (5) tick();
        chk("starve_5", starve_cnt, 5);
        chk("starve_no_push", out_valid, 0);
        repeat (3) tick();
        chk("starve_sat", starve_cnt, 7);
        tick();
        chk("starve_sat_hold", starve_cnt, 7);

        // Synchronous clear beats a push in the same cycle
        clr = 1'b1; rnd_valid = 1'b1;
        #1;
        chk("clr_in_ready", in_ready, 0);
        tick();
        clr = 1'b0; in_valid = 1'b0;
        #1;
        chk("clr_starve", starve_cnt, 0);
        chk("clr_out_valid", out_valid, 0);
        chk("clr_out_shares", out_shares, 0);

        // Reset with two entries held
        in_valid = 1'b1; rnd_valid = 1'b0;
        tick();
        rnd_valid = 1'b1; in_shares = 12'hABC; rnd = 8'hFF;
        tick();
        in_shares = 12'h5A5;
        tick();
        in_valid = 1'b0;
        #1;
        chk("pre_reset_head", out_shares, 12'h5B3);
        chk("pre_reset_full", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_shares", out_shares, 0);
        chk("midreset_starve", starve_cnt, 0);
        chk("midreset_in_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic against the reference queue
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            rnd_valid = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_shares = 12'($urandom);
            rnd       = 8'($urandom);
            #1;
            chk("rand_out_valid", out_valid, (exp_q.size() != 0));
            chk("rand_in_ready", in_ready, (exp_q.size() < DEPTH) && rnd_valid);
            push_m = in_valid && (exp_q.size() < DEPTH) && rnd_valid;
            pop_m  = out_ready && (exp_q.size() != 0);
            chk("rand_rnd_ack", rnd_ack, push_m);
            if (pop_m) begin
                front = exp_q.pop_front();
                chk("rand_out_shares", out_shares, front);
                chk("rand_xor", xor_shares(out_shares), xor_shares(front));
            end
            if (push_m) exp_q.push_back(model_refresh(in_shares, rnd));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        while (exp_q.size() != 0) begin
            #1;
            front = exp_q.pop_front();
            chk("drain_out_valid", out_valid, 1);
            chk("drain_out_shares", out_shares, front);
            tick();
        end
        #1;
        chk("final_empty", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
